// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, command/response records and FSM state encoding
//            for the ALU command master and its wait timer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int OPND_W = 5;
  localparam int RES_W  = 6;
  localparam int AOP_W  = 3;
  localparam int BOP_W  = 2;

  // One ALU command; vectors are MSB-first (bit 0 is the MSB).
  typedef struct packed {
    logic [0:OPND_W-1] a;
    logic [0:OPND_W-1] b;
    logic              a_en;
    logic [0:AOP_W-1]  a_op;
    logic              b_en;
    logic [0:BOP_W-1]  b_op;
  } alu_cmd_t;

  // One response: captured signed result, or a timeout abort with c = 0.
  typedef struct packed {
    logic [0:RES_W-1] c;
    logic             timeout;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } alu_master_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_timer
// Purpose  : Wait counter for the ALU master. Clears to zero, counts while
//            enabled, and flags the last allowed wait cycle (TIMEOUT-1).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Wait counter: held at zero while cleared, otherwise advances when enabled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule : alu_cmd_timer
`default_nettype wire

// File: rtl/alu_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_master
// Purpose  : Initiator for the ALU operand/result interface. Takes one command
//            at a time, drives the operand bus until the ALU strobes c_en (or
//            the wait times out) and returns the result on a response port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [0:OPND_W-1]   cmd_a,
  input  logic [0:OPND_W-1]   cmd_b,
  input  logic                cmd_a_en,
  input  logic [0:AOP_W-1]    cmd_a_op,
  input  logic                cmd_b_en,
  input  logic [0:BOP_W-1]    cmd_b_op,
  output logic                alu_en,
  output logic [0:OPND_W-1]   a,
  output logic [0:OPND_W-1]   b,
  output logic                a_en,
  output logic [0:AOP_W-1]    a_op,
  output logic                b_en,
  output logic [0:BOP_W-1]    b_op,
  input  logic                c_en,
  input  logic [0:RES_W-1]    c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [0:RES_W-1]    rsp_c,
  output logic                rsp_timeout,
  output logic [CNT_W-1:0]    op_count,
  output logic                err_spurious,
  output logic                err_timeout
);

  alu_master_state_e state, state_n;

  alu_cmd_t         cmd_q, cmd_n;
  alu_rsp_t         rsp_q, rsp_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             err_t_q, err_t_n;
  logic             err_s_q, err_s_n;
  logic             ready_q, alu_en_q, rsp_valid_q;
  logic             expired;

  // Wait timer only runs in WAIT; it restarts from zero on every entry.
  alu_cmd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != WAIT),
    .enable  (!c_en),
    .expired (expired)
  );

  // Next-state and next-register values; outputs are registered from these.
  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    rsp_n   = rsp_q;
    count_n = count_q;
    err_t_n = err_t_q;
    err_s_n = err_s_q | (c_en && (state != WAIT));

    case (state)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          cmd_n = '{a: cmd_a, b: cmd_b, a_en: cmd_a_en, a_op: cmd_a_op,
                    b_en: cmd_b_en, b_op: cmd_b_op};
          state_n = WAIT;
        end
      end
      WAIT: begin
        // c_en takes priority over a timeout firing in the same cycle.
        if (c_en) begin
          rsp_n   = '{c: c, timeout: 1'b0};
          count_n = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
          cmd_n   = '0;
          state_n = RESP;
        end else if (expired) begin
          rsp_n   = '{c: '0, timeout: 1'b1};
          err_t_n = 1'b1;
          cmd_n   = '0;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        cmd_n   = '0;
        rsp_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; handshake outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      count_q     <= '0;
      err_t_q     <= 1'b0;
      err_s_q     <= 1'b0;
      ready_q     <= 1'b1;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_q       <= cmd_n;
      rsp_q       <= rsp_n;
      count_q     <= count_n;
      err_t_q     <= err_t_n;
      err_s_q     <= err_s_n;
      ready_q     <= (state_n == IDLE);
      alu_en_q    <= (state_n == WAIT);
      rsp_valid_q <= (state_n == RESP);
    end
  end

  assign cmd_ready    = ready_q;
  assign alu_en       = alu_en_q;
  assign a            = cmd_q.a;
  assign b            = cmd_q.b;
  assign a_en         = cmd_q.a_en;
  assign a_op         = cmd_q.a_op;
  assign b_en         = cmd_q.b_en;
  assign b_op         = cmd_q.b_op;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_c        = rsp_q.c;
  assign rsp_timeout  = rsp_q.timeout;
  assign op_count     = count_q;
  assign err_spurious = err_s_q;
  assign err_timeout  = err_t_q;

endmodule : alu_cmd_master
`default_nettype wire

// File: tb/tb_alu_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_master
// Purpose  : Self-checking bench for alu_cmd_master. Plays the ALU and the
//            response consumer; expectations come from a transaction-level
//            model of latency, timeout, counters and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_master;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [0:4]       cmd_a, cmd_b;
  logic             cmd_a_en, cmd_b_en;
  logic [0:2]       cmd_a_op;
  logic [0:1]       cmd_b_op;
  logic             alu_en;
  logic [0:4]       a, b;
  logic             a_en, b_en;
  logic [0:2]       a_op;
  logic [0:1]       b_op;
  logic             c_en;
  logic [0:5]       c;
  logic             rsp_valid, rsp_ready;
  logic [0:5]       rsp_c;
  logic             rsp_timeout;
  logic [CNT_W-1:0] op_count;
  logic             err_spurious, err_timeout;

  alu_cmd_master #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_en(cmd_a_en), .cmd_a_op(cmd_a_op),
    .cmd_b_en(cmd_b_en), .cmd_b_op(cmd_b_op),
    .alu_en(alu_en), .a(a), .b(b), .a_en(a_en), .a_op(a_op),
    .b_en(b_en), .b_op(b_op), .c_en(c_en), .c(c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_timeout(rsp_timeout), .op_count(op_count),
    .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  int exp_count = 0;
  bit exp_err_t = 1'b0;
  bit exp_err_s = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_count = 0;
    exp_err_t = 1'b0;
    exp_err_s = 1'b0;
  endtask

  task automatic check_flags();
    check("op_count", 32'(op_count), 32'(exp_count));
    check("err_timeout", 32'(err_timeout), 32'(exp_err_t));
    check("err_spurious", 32'(err_spurious), 32'(exp_err_s));
  endtask

  task automatic check_idle();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_alu_en", 32'(alu_en), 32'd0);
    check("idle_a", 32'(a), 32'd0);
    check("idle_b", 32'(b), 32'd0);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check_flags();
  endtask

  // Randomise command fields while they must be ignored.
  task automatic junk_cmd();
    cmd_a    = 5'($urandom);
    cmd_b    = 5'($urandom);
    cmd_a_en = 1'($urandom);
    cmd_a_op = 3'($urandom);
    cmd_b_en = 1'($urandom);
    cmd_b_op = 2'($urandom);
    c        = 6'($urandom);
  endtask

  // One full transaction. Called and returns at a negedge.
  // lat: ALU answers c_en on the lat-th edge after acceptance (lat > TIMEOUT = never).
  task automatic txn(input logic [4:0] ta, input logic [4:0] tb,
                     input logic ta_en, input logic [2:0] taop,
                     input logic tb_en, input logic [1:0] tbop,
                     input int lat, input logic [5:0] tc,
                     input int stall, input bit spur);
    int          n;
    bit          to;
    logic [5:0]  exp_c;
    check("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_a = ta; cmd_b = tb; cmd_a_en = ta_en; cmd_a_op = taop;
    cmd_b_en = tb_en; cmd_b_op = tbop;
    @(negedge clk);
    cmd_valid = 1'b0;
    junk_cmd();
    to = (lat > TIMEOUT);
    n  = to ? TIMEOUT : lat;
    for (int k = 1; k <= n; k++) begin
      check("wait_alu_en", 32'(alu_en), 32'd1);
      check("wait_a", 32'(a), 32'(ta));
      check("wait_b", 32'(b), 32'(tb));
      check("wait_a_en", 32'(a_en), 32'(ta_en));
      check("wait_a_op", 32'(a_op), 32'(taop));
      check("wait_b_en", 32'(b_en), 32'(tb_en));
      check("wait_b_op", 32'(b_op), 32'(tbop));
      check("wait_cmd_ready", 32'(cmd_ready), 32'd0);
      check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      if (!to && k == lat) begin
        c_en = 1'b1;
        c    = tc;
      end
      @(negedge clk);
      c_en = 1'b0;
      c    = 6'($urandom);
    end
    if (to) exp_err_t = 1'b1;
    else if (exp_count < (1 << CNT_W) - 1) exp_count++;
    exp_c = to ? 6'd0 : tc;
    for (int s = 0; s <= stall; s++) begin
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_c", 32'(rsp_c), 32'(exp_c));
      check("rsp_timeout", 32'(rsp_timeout), 32'(to));
      check("rsp_alu_en", 32'(alu_en), 32'd0);
      check("rsp_a", 32'(a), 32'd0);
      check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
      check_flags();
      if (s == stall) begin
        rsp_ready = 1'b1;
      end else begin
        rsp_ready = 1'b0;
        if (spur && s == 0) begin
          c_en = 1'b1;
          exp_err_s = 1'b1;
        end
      end
      @(negedge clk);
      c_en = 1'b0;
    end
    rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("done_cmd_ready", 32'(cmd_ready), 32'd1);
    check("done_alu_en", 32'(alu_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; c_en = 1'b0; rsp_ready = 1'b0;
    junk_cmd();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_idle();

    // Basic command, result three edges after acceptance.
    txn(5'(5), 5'(-3), 1'b1, 3'd0, 1'b0, 2'd0, 3, 6'd2, 0, 1'b0);
    check("basic_count", 32'(op_count), 32'd1);

    // ALU never answers: timeout after exactly TIMEOUT cycles of alu_en.
    txn(5'(7), 5'(1), 1'b0, 3'd0, 1'b1, 2'd3, 1000, 6'd0, 0, 1'b0);
    check("timeout_count_unchanged", 32'(op_count), 32'd1);

    // Result on the very cycle the timeout would fire: c_en wins.
    txn(5'(-1), 5'(2), 1'b1, 3'd5, 1'b0, 2'd1, TIMEOUT, 6'(21), 1, 1'b0);

    // Most negative result held under back-pressure.
    txn(5'(3), 5'(4), 1'b1, 3'd2, 1'b0, 2'd0, 2, 6'(-32), 5, 1'b0);

    // Spurious c_en while idle: sticky flag, no response.
    c_en = 1'b1; c = 6'(9); exp_err_s = 1'b1;
    @(negedge clk);
    c_en = 1'b0;
    repeat (3) begin
      check("spur_no_rsp", 32'(rsp_valid), 32'd0);
      check("spur_sticky", 32'(err_spurious), 32'd1);
      @(negedge clk);
    end
    check_idle();

    // Reset in the middle of WAIT drops the command.
    cmd_valid = 1'b1; cmd_a = 5'(11); cmd_b = 5'(6);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle();
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    txn(5'(-16), 5'(15), 1'b0, 3'd0, 1'b1, 2'd2, 4, 6'(-7), 0, 1'b0);
    check("post_rst_count", 32'(op_count), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      txn(5'($urandom), 5'($urandom), 1'($urandom), 3'($urandom),
          1'($urandom), 2'($urandom),
          int'($urandom_range(1, TIMEOUT + 3)), 6'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_cmd_master
`default_nettype wire

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Initiator side of the ALU operand/result interface: accepts one ALU command at a time from a valid/ready command port and drives the ALU operand bus (alu_en, A, B, a_en/a_op, b_en/b_op).
- Waits for the ALU's result strobe c_en, then returns the captured 6-bit signed result on a valid/ready response port.
- Bounds each wait with a timeout and keeps sticky error flags.
- Sits between the test/stimulus fabric and the ALU, and is also the RTL reference for the bench's driver timing.

Parameters:
- TIMEOUT, 16, cycles in WAIT without c_en before the command is aborted (legal range 1..255).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  [0:4]  signed operand A; bit 0 is the MSB.
- cmd_b  in  [0:4]  signed operand B; bit 0 is the MSB.
- cmd_a_en  in  1  select A-operation group.
- cmd_a_op  in  [0:2]  A-group opcode.
- cmd_b_en  in  1  select B-operation group.
- cmd_b_op  in  [0:1]  B-group opcode.
- alu_en  out  1  ALU enable.
- a  out  [0:4]  operand A to ALU.
- b  out  [0:4]  operand B to ALU.
- a_en  out  1  to ALU.
- a_op  out  [0:2]  to ALU.
- b_en  out  1  to ALU.
- b_op  out  [0:1]  to ALU.
- c_en  in  1  ALU result valid.
- c  in  [0:5]  signed ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_c  out  [0:5]  captured result; 0 on timeout.
- rsp_timeout  out  1  response is a timeout abort.
- op_count  out  CNT_W  completed (non-timeout) operations; saturates at all-ones.
- err_spurious  out  1  sticky: c_en seen outside WAIT.
- err_timeout  out  1  sticky: at least one timeout has occurred.

Behaviour:
- Reset (rst=1 at a posedge):
  - State goes to IDLE.
  - Every output is 0, except cmd_ready, which is 1 from the first cycle after reset.
  - op_count and both sticky flags clear.
  - Any in-flight command or pending response is dropped.
- FSM states are IDLE, WAIT and RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1; alu_en, a, b, a_en, a_op, b_en, b_op are all 0.
  - On cmd_valid&cmd_ready at edge T, all command fields are registered and the FSM moves to WAIT.
  - From cycle T+1, alu_en=1 and the operand outputs carry the command.
- WAIT:
  - cmd_ready=0.
  - Operand outputs and alu_en are held stable every cycle.
  - The wait counter starts at 0 on entry and increments each cycle that c_en=0.
  - If c_en=1: rsp_c<=c, rsp_timeout<=0, op_count increments (saturating), go to RESP.
  - Else, if the wait counter equals TIMEOUT-1: rsp_c<=0, rsp_timeout<=1, err_timeout<=1, go to RESP.
  - If c_en=1 on the cycle the timeout would fire, c_en wins.
  - The earliest possible result therefore gives rsp_valid at T+2 for c_en sampled at T+1.
- RESP:
  - rsp_valid=1; alu_en and all operand outputs return to 0 on entry.
  - rsp_c and rsp_timeout are held until rsp_valid&rsp_ready, then the FSM returns to IDLE.
  - This guarantees at least one alu_en-low cycle between commands.
- Back-pressure: rsp_ready=0 holds RESP indefinitely, with no timeout in RESP; cmd_ready stays 0 throughout.
- c_en=1 sampled in IDLE or RESP sets err_spurious and is otherwise ignored; the result is not captured.
- a_en and b_en are passed through unmodified; the ALU defines their legality. This block does not interpret opcodes.
- No arithmetic on c; it is captured as-is (6-bit signed).
- Reset asserted in WAIT or RESP: next cycle is IDLE with all outputs at their reset values; the aborted command produces no response.

Decomposition:
- Shared package alu_pkg holds:
  - OPND_W=5, RES_W=6, AOP_W=3, BOP_W=2;
  - typedef alu_cmd_t (a, b, a_en, a_op, b_en, b_op);
  - typedef alu_rsp_t (c, timeout);
  - enum alu_master_state_e {IDLE, WAIT, RESP}.
- One natural sub-module, alu_cmd_timer: loadable wait counter that outputs an expired pulse at TIMEOUT-1, with a clear input.
- The FSM, capture registers and counters stay in alu_cmd_master.

Test Plan:
- Reset then idle 10 cycles -> cmd_ready=1; alu_en, a, b, rsp_valid, op_count, err flags all 0.
- Command a=5, b=-3, a_en=1, a_op=0, accepted at T; ALU returns c_en=1, c=2 at T+3 -> alu_en=1 with a=5, b=-3 over T+1..T+3; rsp_valid=1, rsp_c=2, rsp_timeout=0 at T+4; op_count=1.
- Command issued with c_en never asserted, TIMEOUT=16 -> alu_en high exactly 16 cycles; rsp_timeout=1, rsp_c=0, err_timeout=1; op_count unchanged.
- Result c=-32 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_c=-32 stable for all 5 cycles; cmd_ready=0; back in IDLE one cycle after rsp_ready=1.
- c_en=1 pulsed while in IDLE -> err_spurious=1 and sticky; no response generated.
- rst=1 during WAIT, then a new command with a=-16, b=15 -> first command yields no response; second completes normally; op_count=1.
